spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The module SHALL have these parameters, one per line as name, default, meaning:
- DATA_W, 8, frame width in bits (MSB first)
REQ-002 The module SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  system clock; the only clock, SCLK is treated as data
- rst  input  1  reset, synchronous active-low
- CPOL  input  1  SCLK idle level; latched at frame start
- CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start
- tx_data  input  DATA_W  byte to return to the master
- rx_data  output  DATA_W  last fully received byte
- tx_ready  output  1  high while idle (SS high): tx_data may change
- done  output  1  one-clk pulse per completed byte
- SCLK  input  1  serial clock from the master
- SS  input  1  slave select, active-low
- MOSI  input  1  master-out data
- MISO  output  1  slave-out data, 1'bz while SS is high

Function
REQ-003 SCLK, SS and MOSI SHALL each pass a 2-FF synchronizer; edges are detected from the synchronized stream, giving 2–3 clk pin-to-action latency.
REQ-004 The SCLK period SHALL be at least 8 clk cycles and each SCLK phase at least 4 clk; faster SCLK is unsupported.
REQ-005 The leading edge SHALL be rising when CPOL=0 and falling when CPOL=1; the trailing edge is the opposite.
REQ-006 The sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge is the other one.
REQ-007 The FSM states SHALL be IDLE, LOAD, XFER.
- IDLE→LOAD on synchronized SS falling.
- LOAD→XFER after 1 clk.
- XFER→IDLE on SS rising.
REQ-008 In LOAD the block SHALL latch CPOL/CPHA, load tx_data into tx_shift, and clear bit_cnt.
REQ-009 On each sample edge in XFER, rx_shift SHALL shift left with MOSI entering the LSB, and bit_cnt SHALL increment modulo DATA_W.
REQ-010 When bit_cnt wraps (the 8th sample), rx_data SHALL take the new rx_shift value, done SHALL pulse for exactly 1 clk, and tx_shift SHALL reload from tx_data.
REQ-011 For CPHA=0, MISO SHALL present tx_shift[MSB] from the end of LOAD, and tx_shift SHALL shift left on each shift edge, except the shift edge following a reload.
REQ-012 For CPHA=1, tx_shift SHALL shift left on each shift edge except the first shift edge of each byte, so MISO presents bit7 after that first leading edge.
REQ-013 SS held low across byte boundaries SHALL give back-to-back bytes with no gap and no SCLK lost.
REQ-014 If SS rises mid-byte (bit_cnt≠0), the block SHALL abort: partial data is discarded, done stays low, rx_data is unchanged, and the FSM returns to IDLE.
REQ-015 SCLK edges seen while SS is high SHALL be ignored.
REQ-016 A change of CPOL/CPHA during XFER SHALL have no effect until the next frame.
REQ-017 If SS rises and falls in the same clk as the 8th sample edge, the byte SHALL still complete (done pulses) before the FSM returns to IDLE.
REQ-018 tx_ready SHALL be 1 exactly in IDLE.

Reset
REQ-019 With rst=0 at a clk edge, the block SHALL reset: FSM=IDLE; rx_data=0; done=0; tx_ready=1; MISO=z; shift registers, bit_cnt and synchronizers=0 (SS synchronizer=1).
REQ-020 A reset asserted mid-frame SHALL abort the frame without pulsing done; after release the block waits for a fresh SS falling edge, even if SS is still low.

Structure
REQ-021 Package spi_pkg SHALL hold the state typedef (IDLE/LOAD/XFER), DATA_W and the mode typedef {CPOL,CPHA}; it is shared with spi_master.
REQ-022 Sub-module spi_sync_edge (2-FF synchronizer plus rise/fall pulse outputs) SHALL be instantiated for SCLK and SS; MOSI uses the synchronizer only.

Verification
REQ-023 Bench: spi_master drives SCLK/MOSI/SS (SS driven by the bench) with CPOL/CPHA=00, master tx 8'hF0, slave tx_data 8'h3C → slave rx_data=F0 with one done pulse; master rx_data=3C.
REQ-024 Repeat for modes 01/10/11 with master tx 0F/AA/55 and slave tx C3/5A/A5 → each rx byte exact at both ends.
REQ-025 SS low, two master bytes 8'h12 then 8'h34, slave tx_data changed after the first done → two done pulses, rx_data=12 then 34, correct MISO bytes.
REQ-026 SS raised after 4 SCLK cycles → no done, rx_data unchanged; the next full frame 8'h99 is received correctly.
REQ-027 rst=0 applied after 3 bits → MISO=z, done=0, rx_data=0; SS cycled, then frame 8'h81 → rx_data=81.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, slave FSM states and the {CPOL,CPHA} mode pair.
// Used by spi_slave and by spi_master.
package spi_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus one-clk rise/fall pulses
// derived from the synchronized stream.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave for all four CPOL/CPHA modes. SCLK, SS and MOSI are oversampled on clk,
// so SCLK must stay at or below clk/8 with each phase at least 4 clk long.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W = spi_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              tx_ready,
    output logic              done,
    input  logic              SCLK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO
);

    // state | meaning
    // IDLE  | no frame; MISO released, tx_data may change
    // LOAD  | one clk after SS falls: latch mode, preload tx_shift, clear bit_cnt
    // XFER  | sample/shift on SCLK edges until SS rises

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic w_sclk_sync;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_sync;
    logic w_ss_rise;
    logic w_ss_fall;
    logic w_sclk_edge;
    logic w_lead;
    logic w_trail;
    logic w_sample;
    logic w_shift;

    spi_state_e        r_state;
    spi_mode_t         r_mode;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_done;
    logic              r_tx_ready;
    logic              r_skip;
    logic [1:0]        r_settle;
    logic              r_armed;
    logic              r_mosi_meta;
    logic              r_mosi_sync;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_async (SCLK),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_async (SS),
        .o_sync  (w_ss_sync),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    // The level just after an edge tells leading from trailing: leading leaves the idle level.
    assign w_sclk_edge = w_sclk_rise | w_sclk_fall;
    assign w_lead      = w_sclk_edge & (w_sclk_sync ^ r_mode.cpol);
    assign w_trail     = w_sclk_edge & ~(w_sclk_sync ^ r_mode.cpol);
    assign w_sample    = r_mode.cpha ? w_trail : w_lead;
    assign w_shift     = r_mode.cpha ? w_lead : w_trail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mode      <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_bit_cnt   <= '0;
            r_done      <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_skip      <= 1'b0;
            r_settle    <= '0;
            r_armed     <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= MOSI;
            r_mosi_sync <= r_mosi_meta;
            r_done      <= 1'b0;
            // The SS synchronizer holds its reset value for two clks; only a genuinely
            // observed high SS arms frame start, so a pin held low through reset is ignored.
            r_settle    <= {r_settle[0], 1'b1};
            if (r_settle[1] && w_ss_sync) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_ss_fall && r_armed) begin
                        r_state    <= LOAD;
                        r_tx_ready <= 1'b0;
                    end
                end

                LOAD: begin
                    r_mode.cpol <= CPOL;
                    r_mode.cpha <= CPHA;
                    r_tx_shift  <= tx_data;
                    r_rx_shift  <= '0;
                    r_bit_cnt   <= '0;
                    r_skip      <= CPHA;
                    if (w_ss_rise) begin
                        r_state    <= IDLE;
                        r_tx_ready <= 1'b1;
                    end else begin
                        r_state <= XFER;
                    end
                end

                XFER: begin
                    if (w_sample) begin
                        r_rx_shift <= {r_rx_shift[DATA_W-2:0], r_mosi_sync};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt  <= '0;
                            r_rx_data  <= {r_rx_shift[DATA_W-2:0], r_mosi_sync};
                            r_done     <= 1'b1;
                            r_tx_shift <= tx_data;
                            r_skip     <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else if (w_shift) begin
                        if (r_skip) begin
                            r_skip <= 1'b0;
                        end else begin
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    // A sample on the same clk as SS rising is still taken, so a last bit completes.
                    if (w_ss_rise) begin
                        r_state    <= IDLE;
                        r_tx_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_tx_ready <= 1'b1;
                end
            endcase
        end
    end

    assign rx_data  = r_rx_data;
    assign done     = r_done;
    assign tx_ready = r_tx_ready;
    assign MISO     = (r_state == XFER) ? r_tx_shift[DATA_W-1] : 1'bz;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master issues frames; expected slave bytes go
// into a scoreboard queue that a done-triggered monitor pops and compares.
module tb_spi_slave;

    localparam int H = 6;

    localparam logic [7:0] D_MTX [4] = '{8'hF0, 8'h0F, 8'hAA, 8'h55};
    localparam logic [7:0] D_STX [4] = '{8'h3C, 8'hC3, 8'h5A, 8'hA5};

    logic       clk = 1'b0;
    logic       rst;
    logic       CPOL;
    logic       CPHA;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       done;
    logic       SCLK;
    logic       SS;
    logic       MOSI;
    wire        MISO;

    // A released MISO reads as 1 through the pull-up.
    pullup (MISO);

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] q_rx[$];
    logic [7:0] last_rx = 8'h00;
    logic       cpol_m = 1'b0;
    logic       cpha_m = 1'b0;
    logic       done_prev = 1'b0;
    logic [7:0] mrx;

    spi_slave #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .CPOL     (CPOL),
        .CPHA     (CPHA),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .tx_ready (tx_ready),
        .done     (done),
        .SCLK     (SCLK),
        .SS       (SS),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_begin(input logic [1:0] mode);
        cpol_m = mode[1];
        cpha_m = mode[0];
        CPOL   = mode[1];
        CPHA   = mode[0];
        SCLK   = mode[1];
        wait_clk(4);
        SS = 1'b0;
        wait_clk(8);
        // Mode pins are scrambled mid-frame; the latched mode must keep working.
        CPOL = 1'($urandom);
        CPHA = 1'($urandom);
    endtask

    task automatic frame_end();
        wait_clk(H);
        SS = 1'b1;
        wait_clk(8);
    endtask

    task automatic sample_gap(input bit glitch);
        if (glitch) begin
            SS = 1'b1;
            wait_clk(1);
            SS = 1'b0;
            wait_clk(H - 1);
        end else begin
            wait_clk(H);
        end
    endtask

    task automatic spi_byte(input logic [7:0] mtx, input int nbits, input bit glitch,
                            output logic [7:0] m_rx);
        m_rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha_m) begin
                MOSI = mtx[7-i];
                wait_clk(H);
                SCLK = ~cpol_m;
                m_rx = {m_rx[6:0], MISO};
                sample_gap(glitch && (i == nbits - 1));
                SCLK = cpol_m;
            end else begin
                SCLK = ~cpol_m;
                MOSI = mtx[7-i];
                wait_clk(H);
                SCLK = cpol_m;
                m_rx = {m_rx[6:0], MISO};
                sample_gap(glitch && (i == nbits - 1));
            end
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            check("done_width", 32'({done_prev, done}), 32'h1);
            check("spurious_done", 32'(q_rx.size() > 0), 32'h1);
            if (q_rx.size() > 0) begin
                last_rx = q_rx.pop_front();
                check("rx_data", 32'(rx_data), 32'(last_rx));
            end
        end
        done_prev = done;
    end

    initial begin
        rst     = 1'b0;
        CPOL    = 1'b0;
        CPHA    = 1'b0;
        tx_data = 8'h00;
        SCLK    = 1'b0;
        SS      = 1'b1;
        MOSI    = 1'b0;
        wait_clk(3);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h1);
        check("rst_miso_z", 32'(MISO), 32'h1);
        rst = 1'b1;
        wait_clk(6);

        for (int m = 0; m < 4; m++) begin
            tx_data = D_STX[m];
            q_rx.push_back(D_MTX[m]);
            frame_begin(2'(m));
            check("tx_ready_busy", 32'(tx_ready), 32'h0);
            spi_byte(D_MTX[m], 8, 1'b0, mrx);
            check("mode_mrx", 32'(mrx), 32'(D_STX[m]));
            frame_end();
            check("tx_ready_idle", 32'(tx_ready), 32'h1);
            check("idle_miso_z", 32'(MISO), 32'h1);
        end

        // Back-to-back bytes; the second byte returns whatever tx_data held when the
        // first byte completed, since the reload happens at that instant.
        tx_data = 8'h6B;
        frame_begin(2'b00);
        q_rx.push_back(8'h12);
        spi_byte(8'h12, 8, 1'b0, mrx);
        check("b2b_mrx0", 32'(mrx), 32'h6B);
        tx_data = 8'hD2;
        q_rx.push_back(8'h34);
        spi_byte(8'h34, 8, 1'b0, mrx);
        check("b2b_mrx1", 32'(mrx), 32'h6B);
        frame_end();
        check("b2b_rx_last", 32'(rx_data), 32'h34);

        // Abort after four bits.
        tx_data = 8'h96;
        frame_begin(2'b00);
        spi_byte(8'hA5, 4, 1'b0, mrx);
        frame_end();
        check("abort_rx_hold", 32'(rx_data), 32'(last_rx));
        check("abort_tx_ready", 32'(tx_ready), 32'h1);
        q_rx.push_back(8'h99);
        frame_begin(2'b00);
        spi_byte(8'h99, 8, 1'b0, mrx);
        check("after_abort_mrx", 32'(mrx), 32'h96);
        frame_end();

        // Reset in the middle of a frame, SS kept low after release.
        tx_data = 8'h5C;
        frame_begin(2'b00);
        spi_byte(8'hFF, 3, 1'b0, mrx);
        rst = 1'b0;
        wait_clk(2);
        check("midrst_miso_z", 32'(MISO), 32'h1);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_rx_data", 32'(rx_data), 32'h0);
        last_rx = 8'h00;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            MOSI = 1'($urandom);
            wait_clk(H);
            SCLK = 1'b1;
            wait_clk(H);
            SCLK = 1'b0;
        end
        check("midrst_still_idle", 32'(tx_ready), 32'h1);
        SS = 1'b1;
        wait_clk(8);
        q_rx.push_back(8'h81);
        frame_begin(2'b00);
        spi_byte(8'h81, 8, 1'b0, mrx);
        check("post_rst_mrx", 32'(mrx), 32'h5C);
        frame_end();
        check("post_rst_rx", 32'(rx_data), 32'h81);

        // SS glitch coinciding with the eighth sample edge.
        tx_data = 8'h3A;
        q_rx.push_back(8'hC7);
        frame_begin(2'b00);
        spi_byte(8'hC7, 8, 1'b1, mrx);
        check("glitch_mrx", 32'(mrx), 32'h3A);
        frame_end();

        for (int f = 0; f < 16; f++) begin
            logic [1:0] mode;
            int         nb;
            logic [7:0] stx;
            logic [7:0] mb;
            mode    = 2'($urandom_range(3));
            nb      = int'($urandom_range(3, 1));
            stx     = 8'($urandom);
            tx_data = stx;
            frame_begin(mode);
            for (int b = 0; b < nb; b++) begin
                mb = 8'($urandom);
                q_rx.push_back(mb);
                spi_byte(mb, 8, 1'b0, mrx);
                check("rand_mrx", 32'(mrx), 32'(stx));
            end
            frame_end();
        end

        wait_clk(20);
        check("pending_bytes", 32'(q_rx.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
